// File: rtl/char_buffer_ram.sv
// char_buffer_ram: COLS x ROWS character grid for the text overlay.
// Cursor-based write port for game logic, registered {row,col} read port
// for the draw pipeline, and a clear sequencer that fills the grid
// (last row gets its own footer code).
//
// Handshake: a write transfers on a rising edge where wr_valid && wr_ready;
// wr_ready is simply !busy, so it never depends on wr_valid, and a write
// offered while the clear sequencer runs is dropped (not held off).
module char_buffer_ram #(
  parameter int                 COLS          = 16,
  parameter int                 ROWS          = 16,
  parameter int                 CODE_W        = 7,
  parameter logic [CODE_W-1:0]  FILL_CODE     = 7'h20,
  parameter logic [CODE_W-1:0]  LAST_ROW_CODE = 7'h0e,
  parameter int                 COL_W         = $clog2(COLS),
  parameter int                 ROW_W         = $clog2(ROWS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ROW_W+COL_W-1:0]  char_xy,
  output logic [CODE_W-1:0]       char_code,
  input  logic                    clear,
  output logic                    busy,
  input  logic                    cur_set,
  input  logic [COL_W-1:0]        cur_col_in,
  input  logic [ROW_W-1:0]        cur_row_in,
  input  logic                    wr_valid,
  input  logic [CODE_W-1:0]       wr_code,
  output logic                    wr_ready,
  output logic [COL_W-1:0]        cur_col,
  output logic [ROW_W-1:0]        cur_row
);

  localparam int DEPTH = COLS * ROWS;
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [COL_W-1:0]   clr_col_q, clr_col_d;
  logic [ROW_W-1:0]   clr_row_q, clr_row_d;
  logic [COL_W-1:0]   cur_col_q, cur_col_d;
  logic [ROW_W-1:0]   cur_row_q, cur_row_d;
  logic [CODE_W-1:0]  char_code_q, char_code_d;

  logic [CODE_W-1:0]  mem [DEPTH];

  logic               clr_last;
  logic               leave_clear;
  logic               wr_fire;
  logic [COL_W-1:0]   ld_col;
  logic [ROW_W-1:0]   ld_row;
  logic [COL_W-1:0]   pos_col;
  logic [ROW_W-1:0]   pos_row;
  logic               mem_we;
  logic [IDX_W-1:0]   mem_addr;
  logic [CODE_W-1:0]  mem_wdata;
  logic [COL_W-1:0]   rd_col;
  logic [ROW_W-1:0]   rd_row;

  // Linear cell index row*COLS+col; only used with in-range coordinates.
  function automatic logic [IDX_W-1:0] lin_idx(input logic [ROW_W-1:0] r,
                                               input logic [COL_W-1:0] c);
    int t;
    t = int'(r) * COLS + int'(c);
    return IDX_W'(t);
  endfunction

  assign busy      = (state_q == ST_CLEAR);
  assign wr_ready  = !busy;
  assign cur_col   = cur_col_q;
  assign cur_row   = cur_row_q;
  assign char_code = char_code_q;

  // Clear sequencer next state: walks (row,col) over the grid one cell per cycle.
  always_comb begin
    state_d     = state_q;
    clr_col_d   = clr_col_q;
    clr_row_d   = clr_row_q;
    clr_last    = (clr_col_q == COL_MAX) && (clr_row_q == ROW_MAX);
    leave_clear = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (clear) begin
          clr_col_d = '0;
          clr_row_d = '0;
        end else if (clr_last) begin
          state_d     = ST_IDLE;
          clr_col_d   = '0;
          clr_row_d   = '0;
          leave_clear = 1'b1;
        end else if (clr_col_q == COL_MAX) begin
          clr_col_d = '0;
          clr_row_d = clr_row_q + 1'b1;
        end else begin
          clr_col_d = clr_col_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clear) begin
          state_d   = ST_CLEAR;
          clr_col_d = '0;
          clr_row_d = '0;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_col_d = '0;
        clr_row_d = '0;
      end
    endcase
  end

  // Cursor: clamped load has priority; an accepted write lands at the
  // (possibly just-loaded) position and the cursor moves one cell past it.
  always_comb begin
    ld_col    = (int'(cur_col_in) >= COLS) ? COL_MAX : cur_col_in;
    ld_row    = (int'(cur_row_in) >= ROWS) ? ROW_MAX : cur_row_in;
    wr_fire   = wr_valid && !busy;
    pos_col   = cur_set ? ld_col : cur_col_q;
    pos_row   = cur_set ? ld_row : cur_row_q;
    cur_col_d = cur_col_q;
    cur_row_d = cur_row_q;
    if (wr_fire) begin
      if (pos_col == COL_MAX) begin
        cur_col_d = '0;
        cur_row_d = (pos_row == ROW_MAX) ? '0 : pos_row + 1'b1;
      end else begin
        cur_col_d = pos_col + 1'b1;
        cur_row_d = pos_row;
      end
    end else if (cur_set) begin
      cur_col_d = ld_col;
      cur_row_d = ld_row;
    end else if (leave_clear) begin
      cur_col_d = '0;
      cur_row_d = '0;
    end
  end

  // Array write port: clear sequencer while busy, otherwise the cursor write.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (busy) begin
      mem_we    = 1'b1;
      mem_addr  = lin_idx(clr_row_q, clr_col_q);
      mem_wdata = (clr_row_q == ROW_MAX) ? LAST_ROW_CODE : FILL_CODE;
    end else if (wr_fire) begin
      mem_we    = 1'b1;
      mem_addr  = lin_idx(pos_row, pos_col);
      mem_wdata = wr_code;
    end
  end

  // Read data: off-grid addresses give the fill code, and while clearing the
  // result follows the clear rule so the overlay never shows stale cells.
  always_comb begin
    rd_col = char_xy[COL_W-1:0];
    rd_row = char_xy[COL_W +: ROW_W];
    if ((int'(rd_col) >= COLS) || (int'(rd_row) >= ROWS)) begin
      char_code_d = FILL_CODE;
    end else if (busy) begin
      char_code_d = (rd_row == ROW_MAX) ? LAST_ROW_CODE : FILL_CODE;
    end else begin
      char_code_d = mem[lin_idx(rd_row, rd_col)];
    end
  end

  // Control and read-data registers; reset starts a full clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_col_q   <= '0;
      clr_row_q   <= '0;
      cur_col_q   <= '0;
      cur_row_q   <= '0;
      char_code_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_col_q   <= clr_col_d;
      clr_row_q   <= clr_row_d;
      cur_col_q   <= cur_col_d;
      cur_row_q   <= cur_row_d;
      char_code_q <= char_code_d;
    end
  end

  // Storage array, not reset; a same-edge read sees the old contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_char_buffer_ram.sv
// Directed bench for char_buffer_ram: a default 16x16 instance and a 10x5
// instance sharing clock and reset.
module tb_char_buffer_ram;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // 16x16 instance
  logic [7:0] char_xy = '0;
  logic [6:0] char_code;
  logic       clear = 1'b0;
  logic       busy;
  logic       cur_set = 1'b0;
  logic [3:0] cur_col_in = '0;
  logic [3:0] cur_row_in = '0;
  logic       wr_valid = 1'b0;
  logic [6:0] wr_code = '0;
  logic       wr_ready;
  logic [3:0] cur_col;
  logic [3:0] cur_row;

  // 10x5 instance
  logic [6:0] xy2 = '0;
  logic [6:0] code2;
  logic       clear2 = 1'b0;
  logic       busy2;
  logic       set2 = 1'b0;
  logic [3:0] col_in2 = '0;
  logic [2:0] row_in2 = '0;
  logic       wv2 = 1'b0;
  logic [6:0] wc2 = '0;
  logic       rdy2;
  logic [3:0] col2;
  logic [2:0] row2;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt;
  int cnt2;

  always #5 clk = ~clk;

  char_buffer_ram u_big (
    .clk(clk), .rst(rst), .char_xy(char_xy), .char_code(char_code),
    .clear(clear), .busy(busy), .cur_set(cur_set), .cur_col_in(cur_col_in),
    .cur_row_in(cur_row_in), .wr_valid(wr_valid), .wr_code(wr_code),
    .wr_ready(wr_ready), .cur_col(cur_col), .cur_row(cur_row)
  );

  char_buffer_ram #(.COLS(10), .ROWS(5)) u_small (
    .clk(clk), .rst(rst), .char_xy(xy2), .char_code(code2),
    .clear(clear2), .busy(busy2), .cur_set(set2), .cur_col_in(col_in2),
    .cur_row_in(row_in2), .wr_valid(wv2), .wr_code(wc2),
    .wr_ready(rdy2), .cur_col(col2), .cur_row(row2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a read address; the result is checked one cycle later.
  task automatic rd(input logic [7:0] a, input logic [6:0] exp, input string tag);
    char_xy = a;
    @(negedge clk);
    check(tag, 32'(char_code), 32'(exp));
  endtask

  task automatic wr(input logic [6:0] code);
    wr_valid = 1'b1;
    wr_code  = code;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic setc(input logic [3:0] c, input logic [3:0] r);
    cur_set    = 1'b1;
    cur_col_in = c;
    cur_row_in = r;
    @(negedge clk);
    cur_set = 1'b0;
  endtask

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    check("rst_char_code", 32'(char_code), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_wr_ready", 32'(wr_ready), 32'h0);
    check("rst_cursor", {24'h0, cur_row, cur_col}, 32'h00);

    // clear after reset: 256 cycles big, 50 cycles small
    rst  = 1'b0;
    cnt  = 0;
    cnt2 = -1;
    while ((busy || busy2) && cnt < 1000) begin
      @(negedge clk);
      cnt++;
      if (!busy2 && cnt2 < 0) cnt2 = cnt;
    end
    check("clear_cycles", 32'(cnt), 32'd256);
    check("small_clear_cycles", 32'(cnt2), 32'd50);
    check("wr_ready_idle", 32'(wr_ready), 32'h1);
    rd(8'h00, 7'h20, "rd_00_fill");
    rd(8'hF3, 7'h0e, "rd_F3_last_row");

    // small instance: footer row, off-grid column, clamped cursor + wrap
    xy2 = 7'h40; @(negedge clk);
    check("small_row4", 32'(code2), 32'h0e);
    xy2 = 7'h0C; @(negedge clk);
    check("small_col12", 32'(code2), 32'h20);
    set2 = 1'b1; col_in2 = 4'd12; row_in2 = 3'd6;
    @(negedge clk);
    set2 = 1'b0;
    check("small_clamp", {24'h0, 1'b0, row2, col2}, 32'h49);
    wv2 = 1'b1; wc2 = 7'h11;
    @(negedge clk);
    wv2 = 1'b0;
    check("small_wrap_cursor", {24'h0, 1'b0, row2, col2}, 32'h00);
    xy2 = 7'h49; @(negedge clk);
    check("small_cell_49", 32'(code2), 32'h11);

    // PLAY at (3,0)
    setc(4'd3, 4'd0);
    wr(7'h50); wr(7'h4C); wr(7'h41); wr(7'h59);
    check("play_cursor", {24'h0, cur_row, cur_col}, 32'h07);
    rd(8'h03, 7'h50, "rd_03_P");
    rd(8'h04, 7'h4C, "rd_04_L");
    rd(8'h05, 7'h41, "rd_05_A");
    rd(8'h06, 7'h59, "rd_06_Y");
    rd(8'h07, 7'h20, "rd_07_fill");

    // end-of-row and end-of-grid wrap
    setc(4'd15, 4'd0);
    wr(7'h41);
    check("wrap_row_cursor", {24'h0, cur_row, cur_col}, 32'h10);
    rd(8'h0F, 7'h41, "rd_0F");
    setc(4'd15, 4'd15);
    wr(7'h42);
    check("wrap_grid_cursor", {24'h0, cur_row, cur_col}, 32'h00);
    rd(8'hFF, 7'h42, "rd_FF");

    // cursor load and write in the same cycle
    cur_set = 1'b1; cur_col_in = 4'd2; cur_row_in = 4'd2;
    wr(7'h55);
    cur_set = 1'b0;
    check("set_wr_cursor", {24'h0, cur_row, cur_col}, 32'h23);
    rd(8'h22, 7'h55, "rd_22_55");

    // read-during-write returns old data
    setc(4'd2, 4'd2);
    char_xy  = 8'h22;
    wr_valid = 1'b1; wr_code = 7'h56;
    @(negedge clk);
    wr_valid = 1'b0;
    check("rdw_old", 32'(char_code), 32'h55);
    @(negedge clk);
    check("rdw_new", 32'(char_code), 32'h56);

    // clear from IDLE, writes during clear, restart at index 100
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_busy", 32'(busy), 32'h1);
    check("clr_wr_ready", 32'(wr_ready), 32'h0);
    wr_valid = 1'b1; wr_code = 7'h7F;
    char_xy  = 8'hF0;
    @(negedge clk);
    check("busy_read_last_row", 32'(char_code), 32'h0e);
    char_xy = 8'h22;
    @(negedge clk);
    check("busy_read_fill", 32'(char_code), 32'h20);
    repeat (98) @(negedge clk);
    check("busy_cursor_hold", {24'h0, cur_row, cur_col}, 32'h23);
    wr_valid = 1'b0;
    clear    = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    cnt = 0;
    while (busy && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check("restart_cycles", 32'(cnt), 32'd256);
    check("post_clear_cursor", {24'h0, cur_row, cur_col}, 32'h00);
    rd(8'h03, 7'h20, "post_clear_03");
    rd(8'hFF, 7'h0e, "post_clear_FF");
    rd(8'h22, 7'h20, "post_clear_22");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/char_buffer_ram.md
Name: char_buffer_ram

Overview:
Writable character buffer for the text overlay. It replaces fixed per-screen character ROMs with a parametrised COLS x ROWS grid of character codes. Game logic streams codes in through a cursor-based write port. The draw_char pipeline reads codes by {row,col} address with one-cycle latency. A built-in clear sequencer fills the grid with a fill code and gives the last row a separate footer code.

Parameters:
COLS, 16, characters per row (>=2)
ROWS, 16, rows (>=2)
CODE_W, 7, character code width
FILL_CODE, 7'h20, code written to rows 0..ROWS-2 on clear
LAST_ROW_CODE, 7'h0e, code written to row ROWS-1 on clear
(derived) COL_W = $clog2(COLS), ROW_W = $clog2(ROWS)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
char_xy  input  ROW_W+COL_W  read address; [COL_W-1:0]=column, upper bits=row
char_code  output  CODE_W  registered read data
clear  input  1  single-cycle request to start a full clear
busy  output  1  high while the clear sequencer runs
cur_set  input  1  load cursor from cur_col_in/cur_row_in
cur_col_in  input  COL_W  cursor column to load
cur_row_in  input  ROW_W  cursor row to load
wr_valid  input  1  write request carrying wr_code
wr_code  input  CODE_W  code to write at the cursor
wr_ready  output  1  write accepted when wr_valid && wr_ready; equals !busy
cur_col  output  COL_W  current cursor column
cur_row  output  ROW_W  current cursor row

Behaviour:
- Storage: COLS*ROWS x CODE_W array, linear index row*COLS+col. The array is not reset.
- Reset (async, rst=1) values:
  - char_code=0, busy=1, wr_ready=0, cur_col=0, cur_row=0.
  - FSM enters CLEAR with clear index 0.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Writes one cell per cycle at index 0,1,...,COLS*ROWS-1.
  - Row ROWS-1 cells get LAST_ROW_CODE; all other cells get FILL_CODE.
  - After the last index, the next state is IDLE. busy falls on the cycle after the final write.
  - The full clear takes exactly COLS*ROWS cycles.
  - Leaving CLEAR sets the cursor to (0,0).
- IDLE: clear=1 moves to CLEAR at index 0 on the next edge.
- clear=1 while already in CLEAR restarts the sequence at index 0.
- Reset asserted mid-clear restarts the sequence after release.
- Cursor load: cur_set loads the cursor in any state and has priority over cursor advance.
- Write (IDLE only):
  - Taking effect: on an accepted write, the array cell at the cursor takes wr_code on that edge.
  - Cursor advance: col+1; if col=COLS-1 then col=0 and row+1; from (COLS-1,ROWS-1) wrap to (0,0).
  - wr_valid while busy: ignored, no array change, cursor unchanged.
- cur_set && accepted write in the same cycle: the write goes to (cur_col_in,cur_row_in), and the cursor ends at that position advanced by one.
- Read:
  - Latency: char_code <= cell[char_xy] one cycle after the address is presented.
  - Read-during-write to the same cell returns the old data.
  - While busy, char_code is driven from the clear rule for the addressed row (FILL_CODE or LAST_ROW_CODE), regardless of array contents.
  - Column field >=COLS or row field >=ROWS (non-power-of-two sizes) returns FILL_CODE.
- Out-of-range cursor loads (>=COLS or >=ROWS) are clamped to COLS-1 / ROWS-1.

Test Plan:
- Release rst → busy=1 for exactly 256 cycles, then 0 and wr_ready=1. Then char_xy=8'h00 gives char_code=7'h20 one cycle later, and char_xy=8'hF3 gives 7'h0e.
- In IDLE: cur_set (col 3, row 0), then four back-to-back writes 'P','L','A','Y'. Expect reads of 8'h03..8'h06 to return those codes, cursor=(7,0), and 8'h07 still 7'h20.
- Cursor at (15,0), write 7'h41 → cell 8'h0F=7'h41, cursor=(0,1). Cursor at (15,15), write 7'h42 → cell 8'hFF=7'h42, cursor=(0,0).
- wr_valid=1 during CLEAR → wr_ready=0, no cell changes, cursor unchanged. clear pulsed at clear index 100 → busy stays high a further 256 cycles from the restart.
- cur_set to (2,2) and wr_valid with 7'h55 in the same cycle → cell 8'h22=7'h55, cursor=(3,2). Write 7'h56 to cell 8'h22 while reading 8'h22 → char_code shows 7'h55 in that cycle's result and 7'h56 on the following read.
- COLS=10, ROWS=5 instance: clear takes 50 cycles, row 4 holds 7'h0e, and reading col 12 returns 7'h20.
